// File: rtl/cpu_pkg.sv
// Shared constants for the P7 five-stage MIPS core: reset PC, exception
// code width/values, the NOP encoding and the pipeline-register header.
package cpu_pkg;

  localparam logic [31:0] PC_DEFAULT = 32'h0000_3000;
  localparam int          EXC_W      = 5;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Fixed-width part of every pipeline boundary; payload and exception
  // code are kept separately because their widths are per-instance.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic        valid;
  } stage_hdr_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream-to-downstream bundle of one pipeline boundary. The stage that
// drives the register uses master; the register itself uses slave.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = 8
);

  logic              en;
  logic              clr;
  logic              exc_flush;
  logic [31:0]       instr_i;
  logic [31:0]       pc_i;
  logic              bd_i;
  logic              valid_i;
  logic [EXC_W-1:0]  exc_i;
  logic [EXC_W-1:0]  loc_exc_i;
  logic [DATA_W-1:0] data_i;

  logic [31:0]       instr_o;
  logic [31:0]       pc_o;
  logic              bd_o;
  logic              valid_o;
  logic [EXC_W-1:0]  exc_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output en, clr, exc_flush, instr_i, pc_i, bd_i, valid_i, exc_i, loc_exc_i, data_i,
    input  instr_o, pc_o, bd_o, valid_o, exc_o, data_o, stall_cnt_o
  );

  modport slave (
    input  en, clr, exc_flush, instr_i, pc_i, bd_i, valid_i, exc_i, loc_exc_i, data_i,
    output instr_o, pc_o, bd_o, valid_o, exc_o, data_o, stall_cnt_o
  );

endinterface

// File: rtl/exc_merge.sv
// Precise-exception merge: an exception carried from an earlier stage beats
// one raised in the current stage; a bubble never raises anything.
// Purely combinational so CP0 request logic can reuse it.
module exc_merge #(
  parameter int EXC_W = 5
) (
  input  logic [EXC_W-1:0] exc_i,
  input  logic [EXC_W-1:0] loc_exc_i,
  input  logic             valid_i,
  output logic [EXC_W-1:0] exc_o
);

  // Priority select: invalid -> none, older exception -> keep, else local
  always_comb begin
    exc_o = '0;
    if (valid_i) begin
      if (exc_i != '0) exc_o = exc_i;
      else             exc_o = loc_exc_i;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// One pipeline-boundary register (F/D, D/E, E/M or M/W). Holds on stall,
// turns into a bubble on clr (keeping PC/BD for EPC), clears fully on an
// exception flush and counts consecutive stall cycles (saturating).
module pipe_stage_reg #(
  parameter int          DATA_W   = 96,
  parameter logic [31:0] PC_RESET = cpu_pkg::PC_DEFAULT,
  parameter int          EXC_W    = cpu_pkg::EXC_W,
  parameter int          CNT_W    = 8
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  import cpu_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam stage_hdr_t       HDR_RST = '{instr: NOP, pc: PC_RESET, bd: 1'b0, valid: 1'b0};

  // Power-up contents equal the reset contents.
  stage_hdr_t        hdr_q  = HDR_RST;
  logic [EXC_W-1:0]  exc_q  = '0;
  logic [DATA_W-1:0] data_q = '0;
  logic [CNT_W-1:0]  cnt_q  = '0;

  logic [EXC_W-1:0]  exc_merged;

  exc_merge #(.EXC_W(EXC_W)) u_exc_merge (
    .exc_i     (bus.exc_i),
    .loc_exc_i (bus.loc_exc_i),
    .valid_i   (bus.valid_i),
    .exc_o     (exc_merged)
  );

  // Boundary register: reset/flush > bubble > hold > load
  always_ff @(posedge clk) begin
    if (!reset || bus.exc_flush) begin
      hdr_q  <= HDR_RST;
      exc_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (bus.clr) begin
      // Bubble keeps PC/BD so CP0 still reports a correct EPC for the slot.
      hdr_q  <= '{instr: NOP, pc: bus.pc_i, bd: bus.bd_i, valid: 1'b0};
      exc_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (!bus.en) begin
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
    end else begin
      hdr_q  <= '{instr: bus.instr_i, pc: bus.pc_i, bd: bus.bd_i, valid: bus.valid_i};
      exc_q  <= exc_merged;
      data_q <= bus.data_i;
      cnt_q  <= '0;
    end
  end

  assign bus.instr_o     = hdr_q.instr;
  assign bus.pc_o        = hdr_q.pc;
  assign bus.bd_o        = hdr_q.bd;
  assign bus.valid_o     = hdr_q.valid;
  assign bus.exc_o       = exc_q;
  assign bus.data_o      = data_q;
  assign bus.stall_cnt_o = cnt_q;

endmodule
